// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port RAM between the load/store unit and a debug/loader port.
// LS has priority for up to MAX_LS_BURST grants while DBG waits. DBG can lock the memory for exclusive use.
module dmem_arbiter #(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 32,
   parameter int MAX_LS_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ls_req_i,
   input  logic              ls_we_i,
   input  logic [ADDR_W-1:0] ls_addr_i,
   input  logic [DATA_W-1:0] ls_wdata_i,
   output logic              ls_gnt_o,
   output logic              ls_rvalid_o,
   output logic [DATA_W-1:0] ls_rdata_o,
   output logic              ls_stall_o,
   input  logic              dbg_req_i,
   input  logic              dbg_we_i,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   input  logic [DATA_W-1:0] dbg_wdata_i,
   input  logic              dbg_lock_i,
   output logic              dbg_gnt_o,
   output logic              dbg_rvalid_o,
   output logic [DATA_W-1:0] dbg_rdata_o,
   output logic [ADDR_W-1:0] mem_a_o,
   output logic              mem_we_o,
   output logic [DATA_W-1:0] mem_d_o,
   input  logic [DATA_W-1:0] mem_q_i
);

   localparam int                CNT_W   = $clog2(MAX_LS_BURST + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_LS_BURST);

   typedef enum logic [0:0] {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_eff;
   logic              arb_mode, ls_gnt, dbg_gnt;
   logic [ADDR_W-1:0] mem_a_q;
   logic [DATA_W-1:0] mem_d_q;
   logic              ls_rd_q, dbg_rd_q;
   logic [DATA_W-1:0] ls_rdata_q, dbg_rdata_q;

   // The cycle that leaves LOCK is arbitrated as a fresh ARB cycle with an empty burst count.
   always_comb begin
      cnt_eff  = (state_q == ST_LOCK) ? {CNT_W{1'b0}} : cnt_q;
      arb_mode = (state_q == ST_ARB) || !dbg_lock_i;
      ls_gnt   = 1'b0;
      dbg_gnt  = 1'b0;
      if (rst) begin
         ls_gnt  = 1'b0;
         dbg_gnt = 1'b0;
      end else if (arb_mode) begin
         ls_gnt  = ls_req_i && (!dbg_req_i || (cnt_eff != CNT_MAX));
         dbg_gnt = dbg_req_i && !ls_gnt;
      end else begin
         ls_gnt  = 1'b0;
         dbg_gnt = dbg_req_i;
      end

      cnt_d = cnt_eff;
      if (dbg_gnt || !dbg_req_i) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (ls_gnt && (cnt_eff != CNT_MAX)) begin
         cnt_d = cnt_eff + CNT_W'(1);
      end else begin
         cnt_d = cnt_eff;
      end

      state_d = ST_ARB;
      if (dbg_lock_i && (dbg_gnt || (state_q == ST_LOCK))) begin
         state_d = ST_LOCK;
      end else begin
         state_d = ST_ARB;
      end

      mem_a_o  = mem_a_q;
      mem_d_o  = mem_d_q;
      mem_we_o = 1'b0;
      if (dbg_gnt) begin
         mem_a_o  = dbg_addr_i;
         mem_d_o  = dbg_wdata_i;
         mem_we_o = dbg_we_i;
      end else if (ls_gnt) begin
         mem_a_o  = ls_addr_i;
         mem_d_o  = ls_wdata_i;
         mem_we_o = ls_we_i;
      end else begin
         mem_we_o = 1'b0;
      end
   end

   // Read return is qualified by rst so a pending response vanishes as soon as reset is seen.
   assign ls_gnt_o     = ls_gnt;
   assign dbg_gnt_o    = dbg_gnt;
   assign ls_stall_o   = !rst && ls_req_i && !ls_gnt;
   assign ls_rvalid_o  = ls_rd_q && !rst;
   assign dbg_rvalid_o = dbg_rd_q && !rst;
   assign ls_rdata_o   = ls_rvalid_o  ? mem_q_i : ls_rdata_q;
   assign dbg_rdata_o  = dbg_rvalid_o ? mem_q_i : dbg_rdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_ARB;
         cnt_q       <= {CNT_W{1'b0}};
         mem_a_q     <= {ADDR_W{1'b0}};
         mem_d_q     <= {DATA_W{1'b0}};
         ls_rd_q     <= 1'b0;
         dbg_rd_q    <= 1'b0;
         ls_rdata_q  <= {DATA_W{1'b0}};
         dbg_rdata_q <= {DATA_W{1'b0}};
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_a_q     <= mem_a_o;
         mem_d_q     <= mem_d_o;
         ls_rd_q     <= ls_gnt && !ls_we_i;
         dbg_rd_q    <= dbg_gnt && !dbg_we_i;
         ls_rdata_q  <= ls_rdata_o;
         dbg_rdata_q <= dbg_rdata_o;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port RAM (1-cycle read latency).
module tb_dmem_arbiter;

   localparam logic Z = 1'b0;
   localparam logic O = 1'b1;

   typedef struct packed {
      logic        lr, lw;
      logic [7:0]  la;
      logic [31:0] ld;
      logic        dr, dw;
      logic [7:0]  da;
      logic [31:0] dd;
      logic        lk, rs;
      logic        e_lg, e_dg, e_st, e_lv, e_dv, e_we;
      logic [7:0]  e_a;
      logic [31:0] e_lrd, e_drd;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        ls_req_i, ls_we_i, ls_gnt_o, ls_rvalid_o, ls_stall_o;
   logic [7:0]  ls_addr_i;
   logic [31:0] ls_wdata_i, ls_rdata_o;
   logic        dbg_req_i, dbg_we_i, dbg_lock_i, dbg_gnt_o, dbg_rvalid_o;
   logic [7:0]  dbg_addr_i;
   logic [31:0] dbg_wdata_i, dbg_rdata_o;
   logic [7:0]  mem_a_o;
   logic        mem_we_o;
   logic [31:0] mem_d_o, mem_q;
   logic [31:0] mem [256];

   int   n_cmp = 0;
   int   n_err = 0;
   int   n_stall;
   vec_t tbl [23];

   dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_LS_BURST(4)) dut (
      .clk(clk), .rst(rst),
      .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
      .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o), .ls_stall_o(ls_stall_o),
      .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
      .dbg_lock_i(dbg_lock_i), .dbg_gnt_o(dbg_gnt_o), .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o),
      .mem_a_o(mem_a_o), .mem_we_o(mem_we_o), .mem_d_o(mem_d_o), .mem_q_i(mem_q)
   );

   always #5 clk = ~clk;

   // Behavioural RAM: read-before-write within a cycle, data returned one cycle after the address.
   always @(posedge clk) begin
      if (mem_we_o) mem[mem_a_o] <= mem_d_o;
      mem_q <= mem[mem_a_o];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic set_in(input logic lr, input logic lw, input logic [7:0] la, input logic [31:0] ld,
                         input logic dr, input logic dw, input logic [7:0] da, input logic [31:0] dd,
                         input logic lk);
      ls_req_i = lr; ls_we_i = lw; ls_addr_i = la; ls_wdata_i = ld;
      dbg_req_i = dr; dbg_we_i = dw; dbg_addr_i = da; dbg_wdata_i = dd; dbg_lock_i = lk;
   endtask

   initial begin
      rst = 1'b1;
      set_in(Z, Z, 8'h00, 32'h0, Z, Z, 8'h00, 32'h0, Z);

      //           lr lw la     ld            dr dw da     dd            lk rs  lg dg st lv dv we  a      lrd           drd
      tbl[0]  = '{Z, Z, 8'h00, 32'h0,        Z, Z, 8'h00, 32'h0,        Z, O,  Z, Z, Z, Z, Z, Z, 8'h00, 32'h0,        32'h0};
      tbl[1]  = '{Z, Z, 8'h00, 32'h0,        Z, Z, 8'h00, 32'h0,        Z, Z,  Z, Z, Z, Z, Z, Z, 8'h00, 32'h0,        32'h0};
      tbl[2]  = '{Z, Z, 8'h00, 32'h0,        O, O, 8'h10, 32'hDEADBEEF, Z, Z,  Z, O, Z, Z, Z, O, 8'h10, 32'h0,        32'h0};
      tbl[3]  = '{Z, Z, 8'h00, 32'h0,        O, O, 8'h40, 32'h11111111, Z, Z,  Z, O, Z, Z, Z, O, 8'h40, 32'h0,        32'h0};
      tbl[4]  = '{Z, Z, 8'h00, 32'h0,        O, O, 8'h41, 32'h22222222, Z, Z,  Z, O, Z, Z, Z, O, 8'h41, 32'h0,        32'h0};
      tbl[5]  = '{Z, Z, 8'h00, 32'h0,        O, O, 8'h42, 32'h33333333, Z, Z,  Z, O, Z, Z, Z, O, 8'h42, 32'h0,        32'h0};
      tbl[6]  = '{O, Z, 8'h10, 32'h0,        Z, Z, 8'h00, 32'h0,        Z, Z,  O, Z, Z, Z, Z, Z, 8'h10, 32'h0,        32'h0};
      tbl[7]  = '{Z, Z, 8'h00, 32'h0,        Z, Z, 8'h00, 32'h0,        Z, Z,  Z, Z, Z, O, Z, Z, 8'h10, 32'hDEADBEEF, 32'h0};
      tbl[8]  = '{Z, Z, 8'h00, 32'h0,        O, O, 8'h30, 32'h55AA55AA, Z, Z,  Z, O, Z, Z, Z, O, 8'h30, 32'hDEADBEEF, 32'h0};
      tbl[9]  = '{O, Z, 8'h30, 32'h0,        Z, Z, 8'h00, 32'h0,        Z, Z,  O, Z, Z, Z, Z, Z, 8'h30, 32'hDEADBEEF, 32'h0};
      tbl[10] = '{Z, Z, 8'h00, 32'h0,        Z, Z, 8'h00, 32'h0,        Z, Z,  Z, Z, Z, O, Z, Z, 8'h30, 32'h55AA55AA, 32'h0};
      tbl[11] = '{Z, Z, 8'h00, 32'h0,        O, Z, 8'h40, 32'h0,        Z, Z,  Z, O, Z, Z, Z, Z, 8'h40, 32'h55AA55AA, 32'h0};
      tbl[12] = '{Z, Z, 8'h00, 32'h0,        O, Z, 8'h41, 32'h0,        Z, Z,  Z, O, Z, Z, O, Z, 8'h41, 32'h55AA55AA, 32'h11111111};
      tbl[13] = '{Z, Z, 8'h00, 32'h0,        O, Z, 8'h42, 32'h0,        Z, Z,  Z, O, Z, Z, O, Z, 8'h42, 32'h55AA55AA, 32'h22222222};
      tbl[14] = '{Z, Z, 8'h00, 32'h0,        Z, Z, 8'h00, 32'h0,        Z, Z,  Z, Z, Z, Z, O, Z, 8'h42, 32'h55AA55AA, 32'h33333333};
      tbl[15] = '{Z, Z, 8'h00, 32'h0,        Z, Z, 8'h00, 32'h0,        Z, Z,  Z, Z, Z, Z, Z, Z, 8'h42, 32'h55AA55AA, 32'h33333333};
      tbl[16] = '{O, Z, 8'h10, 32'h0,        Z, Z, 8'h00, 32'h0,        Z, Z,  O, Z, Z, Z, Z, Z, 8'h10, 32'h55AA55AA, 32'h33333333};
      tbl[17] = '{Z, Z, 8'h00, 32'h0,        Z, Z, 8'h00, 32'h0,        Z, O,  Z, Z, Z, Z, Z, Z, 8'h10, 32'h55AA55AA, 32'h33333333};
      tbl[18] = '{Z, Z, 8'h00, 32'h0,        Z, Z, 8'h00, 32'h0,        Z, Z,  Z, Z, Z, Z, Z, Z, 8'h00, 32'h0,        32'h0};
      tbl[19] = '{O, O, 8'h50, 32'hCAFE0001, O, Z, 8'h10, 32'h0,        Z, Z,  O, Z, Z, Z, Z, O, 8'h50, 32'h0,        32'h0};
      tbl[20] = '{Z, Z, 8'h00, 32'h0,        O, Z, 8'h10, 32'h0,        Z, Z,  Z, O, Z, Z, Z, Z, 8'h10, 32'h0,        32'h0};
      tbl[21] = '{O, Z, 8'h50, 32'h0,        Z, Z, 8'h00, 32'h0,        Z, Z,  O, Z, Z, Z, O, Z, 8'h50, 32'h0,        32'hDEADBEEF};
      tbl[22] = '{Z, Z, 8'h00, 32'h0,        Z, Z, 8'h00, 32'h0,        Z, Z,  Z, Z, Z, O, Z, Z, 8'h50, 32'hCAFE0001, 32'hDEADBEEF};

      @(negedge clk);
      for (int i = 0; i < 23; i++) begin
         rst = tbl[i].rs;
         set_in(tbl[i].lr, tbl[i].lw, tbl[i].la, tbl[i].ld, tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd, tbl[i].lk);
         #1;
         chk($sformatf("r%0d_ls_gnt", i),     ls_gnt_o,     tbl[i].e_lg);
         chk($sformatf("r%0d_dbg_gnt", i),    dbg_gnt_o,    tbl[i].e_dg);
         chk($sformatf("r%0d_stall", i),      ls_stall_o,   tbl[i].e_st);
         chk($sformatf("r%0d_ls_rvalid", i),  ls_rvalid_o,  tbl[i].e_lv);
         chk($sformatf("r%0d_dbg_rvalid", i), dbg_rvalid_o, tbl[i].e_dv);
         chk($sformatf("r%0d_mem_we", i),     mem_we_o,     tbl[i].e_we);
         chk($sformatf("r%0d_mem_a", i),      mem_a_o,      tbl[i].e_a);
         chk($sformatf("r%0d_ls_rdata", i),   ls_rdata_o,   tbl[i].e_lrd);
         chk($sformatf("r%0d_dbg_rdata", i),  dbg_rdata_o,  tbl[i].e_drd);
         @(negedge clk);
      end

      // Both requesters held: LS gets four in a row, then DBG is forced in.
      for (int i = 0; i < 10; i++) begin
         set_in(O, Z, 8'h60, 32'h0, O, Z, 8'h61, 32'h0, Z);
         #1;
         chk($sformatf("burst%0d_ls_gnt", i),  ls_gnt_o,   (i != 4 && i != 9));
         chk($sformatf("burst%0d_dbg_gnt", i), dbg_gnt_o,  (i == 4 || i == 9));
         chk($sformatf("burst%0d_stall", i),   ls_stall_o, (i == 4 || i == 9));
         chk($sformatf("burst%0d_mem_a", i),   mem_a_o,    (i == 4 || i == 9) ? 32'h61 : 32'h60);
         @(negedge clk);
      end
      set_in(Z, Z, 8'h00, 32'h0, Z, Z, 8'h00, 32'h0, Z);
      @(negedge clk);

      // Locked DBG writes 0x20..0x22 after an LS burst; LS stalls until lock drops.
      n_stall = 0;
      for (int i = 0; i < 8; i++) begin
         if (i < 5)       set_in(O, Z, 8'h70, 32'h0, O, O, 8'h20, 32'h1, O);
         else if (i == 5) set_in(O, Z, 8'h70, 32'h0, O, O, 8'h21, 32'h2, O);
         else if (i == 6) set_in(O, Z, 8'h70, 32'h0, O, O, 8'h22, 32'h3, O);
         else             set_in(O, Z, 8'h70, 32'h0, Z, Z, 8'h00, 32'h0, Z);
         #1;
         if (ls_stall_o) n_stall++;
         chk($sformatf("lock%0d_ls_gnt", i),  ls_gnt_o,  (i < 4 || i == 7));
         chk($sformatf("lock%0d_dbg_gnt", i), dbg_gnt_o, (i >= 4 && i <= 6));
         chk($sformatf("lock%0d_mem_we", i),  mem_we_o,  (i >= 4 && i <= 6));
         @(negedge clk);
      end
      chk("lock_stall_cycles", n_stall, 32'd3);

      // Lock held with no DBG request: memory sits idle and LS stays refused.
      set_in(Z, Z, 8'h00, 32'h0, O, O, 8'h23, 32'h44, O);
      #1; chk("lkidle_dbg_gnt", dbg_gnt_o, 32'd1);
      @(negedge clk);
      set_in(O, Z, 8'h70, 32'h0, Z, Z, 8'h00, 32'h0, O);
      #1; chk("lkidle_ls_gnt", ls_gnt_o, 32'd0); chk("lkidle_stall", ls_stall_o, 32'd1);
      chk("lkidle_mem_we", mem_we_o, 32'd0); chk("lkidle_dbg_gnt2", dbg_gnt_o, 32'd0);
      @(negedge clk);
      set_in(O, Z, 8'h70, 32'h0, Z, Z, 8'h00, 32'h0, Z);
      #1; chk("lkexit_ls_gnt", ls_gnt_o, 32'd1);
      @(negedge clk);

      // Read back the locked writes through DBG.
      for (int i = 0; i < 5; i++) begin
         if (i < 4) set_in(Z, Z, 8'h00, 32'h0, O, Z, 8'h20 + 8'(i), 32'h0, Z);
         else       set_in(Z, Z, 8'h00, 32'h0, Z, Z, 8'h00, 32'h0, Z);
         #1;
         if (i > 0) begin
            chk($sformatf("rb%0d_dbg_rvalid", i), dbg_rvalid_o, 32'd1);
            chk($sformatf("rb%0d_dbg_rdata", i),  dbg_rdata_o,  (i == 4) ? 32'h44 : 32'(i));
         end
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
